// File: rtl/hazard_pkg.sv
// Shared definitions for the hazard/forwarding controller: forward-select
// encodings, stall-FSM state enum, stall-need constants and a small helper.
package hazard_pkg;

    // Operand mux selects, shared by the EX-stage and ID-stage compare muxes
    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b10;
    localparam logic [1:0] FWD_MEMWB = 2'b01;

    // Number of stall cycles a detected dependency requires
    localparam int         NEED_W    = 2;
    localparam logic [1:0] NEED_NONE = 2'd0;
    localparam logic [1:0] NEED_ONE  = 2'd1;
    localparam logic [1:0] NEED_TWO  = 2'd2;

    typedef enum logic {
        RUN  = 1'b0,
        HOLD = 1'b1
    } stall_state_t;

    // Larger of two stall needs; the worst dependency sets the stall length
    function automatic logic [1:0] need_max(input logic [1:0] a, input logic [1:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/hazard_stall_fsm.sv
// Registered stall sequencer. Takes the per-cycle stall need from the
// comparator logic, asserts stall in the same cycle, and holds a second
// stall cycle for load-before-branch dependencies.
// Optional macro HAZARD_PERF_CNT_EN adds saturating performance counters.
module hazard_stall_fsm
    import hazard_pkg::*;
#(
    parameter int CNT_W  = 2,
    parameter int PERF_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        need,
    input  logic              lu_evt,
    input  logic              br_evt,
    output logic              stall,
    output logic [PERF_W-1:0] perf_stall_cnt,
    output logic [PERF_W-1:0] perf_lu_cnt,
    output logic [PERF_W-1:0] perf_br_cnt
);

    stall_state_t     state_r;
    stall_state_t     state_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic             stall_s;

    // State and remaining-hold counter; reset aborts any stall in progress
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= RUN;
            cnt_r   <= {CNT_W{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // Next state and same-cycle stall; detection is ignored while holding
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        stall_s     = 1'b0;
        case (state_r)
            RUN: begin
                if (need != NEED_NONE) begin
                    stall_s = 1'b1;
                    if (need == NEED_TWO) begin
                        state_nxt_s = HOLD;
                        cnt_nxt_s   = CNT_W'(1'b1);
                    end else begin
                        state_nxt_s = RUN;
                    end
                end else begin
                    stall_s = 1'b0;
                end
            end
            HOLD: begin
                stall_s = 1'b1;
                if (cnt_r != {CNT_W{1'b0}}) begin
                    cnt_nxt_s = cnt_r - CNT_W'(1'b1);
                end else begin
                    cnt_nxt_s = {CNT_W{1'b0}};
                end
                if (cnt_r <= CNT_W'(1'b1)) begin
                    state_nxt_s = RUN;
                end else begin
                    state_nxt_s = HOLD;
                end
            end
            default: begin
                state_nxt_s = RUN;
                cnt_nxt_s   = {CNT_W{1'b0}};
                stall_s     = 1'b0;
            end
        endcase
    end

    assign stall = stall_s;

`ifdef HAZARD_PERF_CNT_EN
    logic [PERF_W-1:0] stall_cnt_r;
    logic [PERF_W-1:0] lu_cnt_r;
    logic [PERF_W-1:0] br_cnt_r;
    logic              entry_s;

    // A stall is entered from RUN; both causes may count on the same entry
    assign entry_s = (state_r == RUN) && (need != NEED_NONE);

    // Saturating event counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_r <= {PERF_W{1'b0}};
            lu_cnt_r    <= {PERF_W{1'b0}};
            br_cnt_r    <= {PERF_W{1'b0}};
        end else begin
            if (stall_s && (stall_cnt_r != {PERF_W{1'b1}})) begin
                stall_cnt_r <= stall_cnt_r + PERF_W'(1'b1);
            end
            if (entry_s && lu_evt && (lu_cnt_r != {PERF_W{1'b1}})) begin
                lu_cnt_r <= lu_cnt_r + PERF_W'(1'b1);
            end
            if (entry_s && br_evt && (br_cnt_r != {PERF_W{1'b1}})) begin
                br_cnt_r <= br_cnt_r + PERF_W'(1'b1);
            end
        end
    end

    assign perf_stall_cnt = stall_cnt_r;
    assign perf_lu_cnt    = lu_cnt_r;
    assign perf_br_cnt    = br_cnt_r;
`else
    logic unused_evt_s;

    assign unused_evt_s   = lu_evt ^ br_evt;
    assign perf_stall_cnt = {PERF_W{1'b0}};
    assign perf_lu_cnt    = {PERF_W{1'b0}};
    assign perf_br_cnt    = {PERF_W{1'b0}};
`endif

endmodule

// File: rtl/hazard_forward_ctrl.sv
// Forwarding and hazard-stall controller for the 5-stage MIPS pipeline.
// Combinational EX/ID forward selects and dependency detection; stall
// sequencing lives in hazard_stall_fsm.
// Optional macro HAZARD_PERF_CNT_EN enables the perf_* counters.
module hazard_forward_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_AW   = 5,
    parameter bit ZERO_REG = 1'b1,
    parameter int CNT_W    = 2,
    parameter int PERF_W   = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] if_id_rs,
    input  logic [REG_AW-1:0] if_id_rt,
    input  logic              if_id_use_rt,
    input  logic              if_id_branch,
    input  logic [REG_AW-1:0] id_ex_rs,
    input  logic [REG_AW-1:0] id_ex_rt,
    input  logic [REG_AW-1:0] id_ex_dst,
    input  logic              id_ex_write,
    input  logic              id_ex_mem_read,
    input  logic [REG_AW-1:0] ex_mem_dst,
    input  logic              ex_mem_write,
    input  logic              ex_mem_mem_read,
    input  logic [REG_AW-1:0] mem_wb_dst,
    input  logic              mem_wb_write,
    output logic [1:0]        fwd_ex_a,
    output logic [1:0]        fwd_ex_b,
    output logic [1:0]        fwd_id_a,
    output logic [1:0]        fwd_id_b,
    output logic              pc_write,
    output logic              if_id_write,
    output logic              id_ex_bubble,
    output logic              stall,
    output logic [PERF_W-1:0] perf_stall_cnt,
    output logic [PERF_W-1:0] perf_lu_cnt,
    output logic [PERF_W-1:0] perf_br_cnt
);

    // Register-address match; address 0 never matches when it is hard-wired
    function automatic logic reg_match(input logic [REG_AW-1:0] x, input logic [REG_AW-1:0] y);
        return (x == y) && (!ZERO_REG || (x != {REG_AW{1'b0}}));
    endfunction

    // Operand select for one source: EX/MEM beats MEM/WB
    function automatic logic [1:0] fwd_sel(input logic exmem_ok, input logic [REG_AW-1:0] src);
        if (exmem_ok && reg_match(ex_mem_dst, src)) begin
            return FWD_EXMEM;
        end else if (mem_wb_write && reg_match(mem_wb_dst, src)) begin
            return FWD_MEMWB;
        end else begin
            return FWD_RF;
        end
    endfunction

    logic [1:0] fwd_ex_a_s;
    logic [1:0] fwd_ex_b_s;
    logic [1:0] fwd_id_a_s;
    logic [1:0] fwd_id_b_s;
    logic       ex_hit_s;
    logic       mem_hit_s;
    logic       lu_hit_s;
    logic       br_hit_s;
    logic [1:0] need_s;
    logic       stall_s;

    // EX-stage operand forwarding
    always_comb begin
        fwd_ex_a_s = fwd_sel(ex_mem_write, id_ex_rs);
        fwd_ex_b_s = fwd_sel(ex_mem_write, id_ex_rt);
    end

    // ID-stage branch-compare forwarding; a load in MEM cannot forward yet
    always_comb begin
        fwd_id_a_s = FWD_RF;
        fwd_id_b_s = FWD_RF;
        if (if_id_branch) begin
            fwd_id_a_s = fwd_sel(ex_mem_write && !ex_mem_mem_read, if_id_rs);
            fwd_id_b_s = fwd_sel(ex_mem_write && !ex_mem_mem_read, if_id_rt);
        end else begin
            fwd_id_a_s = FWD_RF;
            fwd_id_b_s = FWD_RF;
        end
    end

    // Dependency detection and the stall length it requires
    always_comb begin
        need_s    = NEED_NONE;
        ex_hit_s  = reg_match(id_ex_dst, if_id_rs) || reg_match(id_ex_dst, if_id_rt);
        mem_hit_s = reg_match(ex_mem_dst, if_id_rs) || reg_match(ex_mem_dst, if_id_rt);
        lu_hit_s  = id_ex_mem_read &&
                    (reg_match(id_ex_dst, if_id_rs) ||
                     (if_id_use_rt && reg_match(id_ex_dst, if_id_rt)));
        br_hit_s  = if_id_branch &&
                    ((id_ex_write && !id_ex_mem_read && ex_hit_s) ||
                     (id_ex_mem_read && ex_hit_s) ||
                     (ex_mem_mem_read && mem_hit_s));
        if (lu_hit_s) begin
            need_s = need_max(need_s, NEED_ONE);
        end else begin
            need_s = need_s;
        end
        if (if_id_branch && id_ex_write && !id_ex_mem_read && ex_hit_s) begin
            need_s = need_max(need_s, NEED_ONE);
        end else begin
            need_s = need_s;
        end
        if (if_id_branch && id_ex_mem_read && ex_hit_s) begin
            need_s = need_max(need_s, NEED_TWO);
        end else begin
            need_s = need_s;
        end
        if (if_id_branch && ex_mem_mem_read && mem_hit_s) begin
            need_s = need_max(need_s, NEED_ONE);
        end else begin
            need_s = need_s;
        end
    end

    hazard_stall_fsm #(
        .CNT_W  (CNT_W),
        .PERF_W (PERF_W)
    ) u_stall_fsm (
        .clk            (clk),
        .rst_n          (rst_n),
        .need           (need_s),
        .lu_evt         (lu_hit_s),
        .br_evt         (br_hit_s),
        .stall          (stall_s),
        .perf_stall_cnt (perf_stall_cnt),
        .perf_lu_cnt    (perf_lu_cnt),
        .perf_br_cnt    (perf_br_cnt)
    );

    assign fwd_ex_a     = fwd_ex_a_s;
    assign fwd_ex_b     = fwd_ex_b_s;
    assign fwd_id_a     = fwd_id_a_s;
    assign fwd_id_b     = fwd_id_b_s;
    assign pc_write     = ~stall_s;
    assign if_id_write  = ~stall_s;
    assign id_ex_bubble = stall_s;
    assign stall        = stall_s;

endmodule
